// File: rtl/riscv_pkg.sv
// Shared definitions for the EX-stage operand hazard controller:
// forwarding select encoding, tracker entry layout and the hit test.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } hz_entry_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam hz_entry_t HZ_ENTRY_NONE = '{valid: 1'b0, rd: REG_X0, regwrite: 1'b0, memread: 1'b0};

    // A source operand depends on an in-flight producer. x0 never matches.
    function automatic logic hz_hit(input hz_entry_t e, input logic [4:0] rs, input logic use_rs);
        return e.valid & e.regwrite & (e.rd != REG_X0) & (e.rd == rs) & use_rs;
    endfunction

    // Newer producer (currently in EX) beats the older one (currently in MEM).
    function automatic fwd_sel_e hz_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_tracker.sv
// Three-entry destination tracker (EX, MEM, WB). Shifts every cycle; the EX
// slot takes the ID instruction when it advances, else an invalid bubble.
module hz_tracker
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_en,
    input  hz_entry_t id_entry,
    output hz_entry_t ex_q,
    output hz_entry_t mem_q,
    output hz_entry_t wb_q
);

    // Pipeline shift with bubble insertion on stall, flush or empty ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= HZ_ENTRY_NONE;
            mem_q <= HZ_ENTRY_NONE;
            wb_q  <= HZ_ENTRY_NONE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= load_en ? id_entry : HZ_ENTRY_NONE;
        end
    end

endmodule

// File: rtl/operand_hazard_ctrl.sv
// Operand hazard controller for the EX-stage ALU path.
// Produces registered forwarding selects for operand 1 and register-side
// operand 2, and a combinational load-use stall/bubble.
// Optional build macro: HAZARD_STATS_EN adds stall_cnt / fwd_cnt counters.
module operand_hazard_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
`ifdef HAZARD_STATS_EN
   ,output logic [31:0] stall_cnt,
    output logic [31:0] fwd_cnt
`endif
);

    hz_entry_t id_entry;
    hz_entry_t ex_q;
    hz_entry_t mem_q;
    hz_entry_t wb_q;
    logic      load_en;
    logic      hit_ex_a;
    logic      hit_ex_b;
    logic      hit_mem_a;
    logic      hit_mem_b;
    fwd_sel_e  fwd_a_d;
    fwd_sel_e  fwd_b_d;

    // WB producers are covered by the write-through register file, so the
    // WB entry and the memread bit of MEM carry no decision here.
    logic      unused_tracker;
    assign unused_tracker = ^{wb_q, mem_q.memread};

    assign id_entry = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
    assign load_en  = id_valid & ~stall & ~flush;

    hz_tracker u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .id_entry (id_entry),
        .ex_q     (ex_q),
        .mem_q    (mem_q),
        .wb_q     (wb_q)
    );

    // Dependency checks of the ID sources against EX and MEM producers.
    always_comb begin
        hit_ex_a  = hz_hit(ex_q,  id_rs1, id_use_rs1);
        hit_ex_b  = hz_hit(ex_q,  id_rs2, id_use_rs2);
        hit_mem_a = hz_hit(mem_q, id_rs1, id_use_rs1);
        hit_mem_b = hz_hit(mem_q, id_rs2, id_use_rs2);
    end

    // Load in EX feeding the ID instruction: hold one cycle. Flush wins.
    always_comb begin
        stall  = id_valid & ~flush & ex_q.memread & (hit_ex_a | hit_ex_b);
        bubble = stall;
    end

    // Next selects; forced to register file when the instruction won't enter EX.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (load_en) begin
            fwd_a_d = hz_sel(hit_ex_a, hit_mem_a);
            fwd_b_d = hz_sel(hit_ex_b, hit_mem_b);
        end
    end

    // Selects captured alongside the ID/EX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating hazard statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if ((fwd_a_d != FWD_RF || fwd_b_d != FWD_RF) && fwd_cnt != 32'hFFFF_FFFF)
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Directed self-checking bench for operand_hazard_ctrl.
module tb_operand_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    operand_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .bubble      (bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
`ifdef HAZARD_STATS_EN
       ,.stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic rw, input logic mr, input logic fl);
        id_valid    = v;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
    endtask

    // Apply one ID-stage cycle: check stall/bubble before the edge, selects after.
    task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic rw,
                        input logic mr, input logic fl, input logic exp_stall,
                        input logic [1:0] ea, input logic [1:0] eb);
        drive(v, rd, rs1, rs2, u1, u2, rw, mr, fl);
        #1;
        chk({tag, ".stall"},  {31'd0, stall},  {31'd0, exp_stall});
        chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        chk({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, ea});
        chk({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, eb});
    endtask

    task automatic nop_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset.stall", {31'd0, stall}, 32'd0);
        chk("reset.fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("reset.fwd_b", {30'd0, fwd_b}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.fwd_cnt",   fwd_cnt,   32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add x5,x1,x2 ; sub x8,x5,x9
        step("t1.add", 1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t1.sub", 1, 8, 5, 9, 1, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        nop_cycles(3);

        // add x5 ; nop ; or x1,x2,x5
        step("t2.add", 1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t2.nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("t2.or",  1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b10);
        nop_cycles(3);

        // lw x6,0(x1) ; add x7,x1,x6 (stalls once, then forwards from MEM/WB)
        step("t3.lw",    1, 6, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t3.add.s", 1, 7, 1, 6, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        step("t3.add",   1, 7, 1, 6, 1, 1, 1, 0, 0, 0, 2'b00, 2'b10);
        nop_cycles(3);

        // addi x0,x0,1 ; add x3,x0,x0
        step("t4.addi", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t4.add",  1, 3, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        nop_cycles(3);

        // lw x6 ; sw with rs2=x6 but use_rs2=0
        step("t4b.lw", 1, 6, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t4b.sw", 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        nop_cycles(3);

        // add x7 ; add x7 ; sub x2,x7,x7
        step("t5.add0", 1, 7, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t5.add1", 1, 7, 3, 4, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t5.sub",  1, 2, 7, 7, 1, 1, 1, 0, 0, 0, 2'b01, 2'b01);
        nop_cycles(3);

        // lw x6 ; add x7,x1,x6 killed by flush ; add x9,x6,x0 sees lw in MEM
        step("t6.lw",    1, 6, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t6.flush", 1, 7, 1, 6, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00);
        step("t6.add",   1, 9, 6, 0, 1, 1, 1, 0, 0, 0, 2'b10, 2'b00);
        nop_cycles(3);

        // lw x6 ; lw x8,0(x6) ; add x1,x8,x0 -- one stall each
        step("t7.lw0",   1, 6, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t7.lw1.s", 1, 8, 6, 0, 1, 0, 1, 1, 0, 1, 2'b00, 2'b00);
        step("t7.lw1",   1, 8, 6, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00);
        step("t7.add.s", 1, 1, 8, 0, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00);
        step("t7.add",   1, 1, 8, 0, 1, 1, 1, 0, 0, 0, 2'b10, 2'b00);
        nop_cycles(3);

        // add x5 ; lw x6,0(x5) ; add x7,x1,x6 stalling when reset hits
        step("t8.add", 1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t8.lw",  1, 6, 5, 0, 1, 0, 1, 1, 0, 0, 2'b01, 2'b00);
        drive(1, 7, 1, 6, 1, 1, 1, 0, 0);
        #1;
        chk("t8.pre.stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8.rst.stall",  {31'd0, stall},  32'd0);
        chk("t8.rst.bubble", {31'd0, bubble}, 32'd0);
        chk("t8.rst.fwd_a",  {30'd0, fwd_a},  32'd0);
        chk("t8.rst.fwd_b",  {30'd0, fwd_b},  32'd0);
`ifdef HAZARD_STATS_EN
        chk("t8.rst.stall_cnt", stall_cnt, 32'd0);
        chk("t8.rst.fwd_cnt",   fwd_cnt,   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("t8.after", 1, 7, 1, 6, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time in case the main sequence stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_hazard_ctrl.md
# operand_hazard_ctrl

Data-hazard controller for the EX-stage ALU operand path of the pipelined RISC-V core. It tracks the destination registers of instructions in EX, MEM and WB, and produces registered forwarding selects for ALU operand 1 and the register-side operand 2. Operand 2 is forwarded before the immediate/register select, so the immediate still wins when the ALU source is the immediate. It also detects load-use hazards and issues a one-cycle stall with a bubble. It sits beside the ID/EX pipeline register, fed from ID-stage decode.

## Interface
Parameters:
- none; widths are fixed by the ISA (5-bit register index, 2-bit select).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  source register indices of the ID instruction
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1 / rs2
- id_rd  in  5  destination register index
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- flush  in  1  taken branch/jump resolved in EX; kills the IF and ID instructions
- stall  out  1  combinational; hold PC and IF/ID
- bubble  out  1  combinational; load NOP into ID/EX
- fwd_a, fwd_b  out  2 each  registered operand-source selects, valid while the instruction is in EX: 00 register file, 01 EX/MEM result, 10 MEM/WB result

## Operation
- Tracker: three entries ex_q, mem_q, wb_q, each holding {valid, rd, regwrite, memread}. Every cycle they shift: wb_q←mem_q, mem_q←ex_q.
- ex_q loads the ID fields when id_valid & !stall & !flush. Otherwise ex_q loads an invalid entry.
- A hit on an entry requires valid & regwrite & rd≠0 & rd==rs & use_rs.
- Load-use: stall = bubble = id_valid & !flush & ex_q.memread & hit(ex_q, rs1 or rs2).
- Forward select for each operand, computed in ID and registered at the edge where the instruction enters EX:
  - hit(ex_q) → 01 (that instruction will be in MEM).
  - else hit(mem_q) → 10 (that instruction will be in WB).
  - else 00.
  - The newer producer always wins.
- A WB-stage producer at ID time needs no forwarding. The register file is write-through: a same-cycle read returns the written value.
- When stalling, flushing or when !id_valid, fwd_a and fwd_b load 00.
- The entry that caused a stall moves to mem_q. On the next cycle the ID instruction is re-evaluated and gets 10.
- x0 is never forwarded and never causes a stall.

## Timing
- Reset (asynchronous, immediate): all tracker entries invalid, fwd_a = fwd_b = 00. stall and bubble are therefore 0.
- stall and bubble: zero-latency combinational outputs from the ID inputs and ex_q.
- fwd_a and fwd_b: one-cycle latency; they change on the same edge that ID/EX captures the instruction.
- A load-use stall lasts exactly one cycle. Back-to-back loads feeding each other still stall one cycle each.
- flush and a load-use condition in the same cycle: flush wins. stall = 0, ex_q is invalid, selects are 00.
- Reset asserted mid-stall: outputs clear immediately. After release the first instruction sees an empty tracker.

## Configuration
- HAZARD_STATS_EN defined: adds two output ports, stall_cnt [31:0] and fwd_cnt [31:0].
  - stall_cnt increments on every stall cycle.
  - fwd_cnt increments on every EX entry with a nonzero fwd_a or fwd_b.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- HAZARD_STATS_EN undefined: the ports and counters are absent. Hazard behaviour is identical in both builds.

## Structure
- Shared package riscv_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - hz_entry_t packed struct {valid, rd[4:0], regwrite, memread}.
  - REG_X0 constant = 5'd0.
- One sub-module, hz_tracker: owns the three-entry shift register with flush/bubble insertion and exposes the entries. Hit, stall and select logic live in the top.

## Test plan
- add x5 followed by sub x8,x5,x9 → no stall; fwd_a=01, fwd_b=00 in the sub's EX cycle.
- add x5, nop, or x1,x2,x5 → fwd_b=10 for the or; stall never asserts.
- lw x6 followed by add x7,x1,x6 → stall=bubble=1 for exactly one cycle; the add then enters EX with fwd_b=10.
- addi x0,x0,1 followed by add x3,x0,x0 → fwd_a=fwd_b=00, no stall. Also: a store with id_use_rs2=0 after lw of the same rd must not stall.
- add x7, add x7, sub x2,x7,x7 → fwd_a=fwd_b=01 (newest producer wins).
- flush asserted during a load-use cycle → stall=0, next fwd=00. Additionally: rst_n pulsed low mid-sequence → all outputs 0 asynchronously, tracker empty after release; with HAZARD_STATS_EN, counters read 0 after reset.
